// File: rtl/mul4bit_mac_seq.sv
// mul4bit_mac_seq: accumulates BURST_LEN 4x4 products and emits the sum.
// Define MUL4BIT_MAC_SATURATE_EN to clamp instead of wrap on overflow.

module mul4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] pp [4];

    // shifted partial-product rows of the array, summed
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pp[i] = b[i] ? (8'(a) << i) : 8'd0;
        end
        p = pp[0] + pp[1] + pp[2] + pp[3];
    end
endmodule

module mul4bit_mac_seq #(
    parameter int BURST_LEN = 4,
    parameter int ACC_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    localparam logic [3:0] LAST = 4'(BURST_LEN - 1);

    state_t           state;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic             v_q;
    logic [3:0]       cnt_in;
    logic [3:0]       cnt_acc;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    logic [7:0]       prod;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_nxt;
    logic             accept;
    logic             last_add;
    logic             out_fire;

    mul4bit u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    assign accept   = in_valid & in_ready;
    assign last_add = v_q & (cnt_acc == LAST);
    assign out_fire = out_valid & out_ready;

    // one-bit-wider add exposes the carry that feeds the sticky overflow
    always_comb begin
        sum     = {1'b0, acc} + (ACC_W + 1)'(prod);
        ovf_nxt = ovf | sum[ACC_W];
`ifdef MUL4BIT_MAC_SATURATE_EN
        acc_nxt = ovf_nxt ? '1 : sum[ACC_W-1:0];
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    // operand capture, accumulate stage, result register and burst FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            v_q       <= 1'b0;
            cnt_in    <= '0;
            cnt_acc   <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            v_q <= accept;
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                cnt_in <= cnt_in + 4'd1;
            end

            if (v_q) begin
                if (last_add) begin
                    out_acc   <= acc_nxt;
                    out_ovf   <= ovf_nxt;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    ovf       <= 1'b0;
                    cnt_in    <= '0;
                    cnt_acc   <= '0;
                end else begin
                    acc     <= acc_nxt;
                    ovf     <= ovf_nxt;
                    cnt_acc <= cnt_acc + 4'd1;
                end
            end

            if (out_fire) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (cnt_in == LAST) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    if (last_add) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul4bit_mac_seq.sv
// tb_mul4bit_mac_seq: directed and random bursts on three configurations.
// Instances: 0 = (4,10), 1 = (4,8), 2 = (1,10).

module tb_mul4bit_mac_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       iv   [3];
    logic [3:0] ia   [3];
    logic [3:0] ib   [3];
    logic       ordy [3];
    logic       irdy [3];
    logic       ovld [3];
    logic       oovf [3];
    logic [9:0] acc0;
    logic [7:0] acc1;
    logic [9:0] acc2;

    int vectors     = 0;
    int miscompares = 0;
    int qa[$];
    int qb[$];

    mul4bit_mac_seq #(.BURST_LEN(4), .ACC_W(10)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_a(ia[0]), .in_b(ib[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]),
        .out_acc(acc0), .out_ovf(oovf[0])
    );

    mul4bit_mac_seq #(.BURST_LEN(4), .ACC_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_a(ia[1]), .in_b(ib[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]),
        .out_acc(acc1), .out_ovf(oovf[1])
    );

    mul4bit_mac_seq #(.BURST_LEN(1), .ACC_W(10)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_a(ia[2]), .in_b(ib[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]),
        .out_acc(acc2), .out_ovf(oovf[2])
    );

    function automatic int blen(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int accw(input int k);
        return (k == 1) ? 8 : 10;
    endfunction

    function automatic logic [31:0] racc(input int k);
        case (k)
            0:       return 32'(acc0);
            1:       return 32'(acc1);
            default: return 32'(acc2);
        endcase
    endfunction

    // reference: plain dot product, then wrap or clamp to the result width
    function automatic void model(input int k, output int ea, output int eo);
        int s;
        int lim;
        s   = 0;
        lim = (1 << accw(k)) - 1;
        foreach (qa[i]) s += qa[i] * qb[i];
        eo = (s > lim) ? 1 : 0;
`ifdef MUL4BIT_MAC_SATURATE_EN
        ea = (s > lim) ? lim : s;
`else
        ea = s % (lim + 1);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ia[k]   = 4'd0;
            ib[k]   = 4'd0;
            ordy[k] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", irdy[k], 1);
            chk("rst_out_valid", ovld[k], 0);
            chk("rst_out_acc", racc(k), 0);
            chk("rst_out_ovf", oovf[k], 0);
        end
    endtask

    // entered and left at a falling edge; checks fixed one-edge latency
    task automatic run_burst(input int k, input bit gap,
                             output int ea, output int eo);
        for (int i = 0; i < qa.size(); i++) begin
            iv[k] = 1'b1;
            ia[k] = 4'(qa[i]);
            ib[k] = 4'(qb[i]);
            chk("in_ready_accept", irdy[k], 1);
            chk("out_valid_busy", ovld[k], 0);
            @(negedge clk);
            if (gap && i + 1 < qa.size()) begin
                iv[k] = 1'b0;
                ia[k] = 4'($urandom);
                ib[k] = 4'($urandom);
                chk("in_ready_gap", irdy[k], 1);
                @(negedge clk);
            end
        end
        iv[k] = 1'b1;
        ia[k] = 4'($urandom);
        ib[k] = 4'($urandom);
        chk("in_ready_drain", irdy[k], 0);
        chk("out_valid_drain", ovld[k], 0);
        @(negedge clk);
        iv[k] = 1'b0;
        model(k, ea, eo);
        chk("out_valid_rise", ovld[k], 1);
        chk("out_acc", racc(k), 32'(ea));
        chk("out_ovf", oovf[k], 32'(eo));
        chk("in_ready_hold", irdy[k], 0);
    endtask

    task automatic release_out(input int k, input int hold,
                               input int ea, input int eo);
        repeat (hold) begin
            iv[k]   = 1'b1;
            ia[k]   = 4'($urandom);
            ib[k]   = 4'($urandom);
            ordy[k] = 1'b0;
            @(negedge clk);
            chk("bp_out_valid", ovld[k], 1);
            chk("bp_in_ready", irdy[k], 0);
            chk("bp_out_acc", racc(k), 32'(ea));
            chk("bp_out_ovf", oovf[k], 32'(eo));
        end
        iv[k]   = 1'b1;
        ia[k]   = 4'($urandom);
        ib[k]   = 4'($urandom);
        ordy[k] = 1'b1;
        @(negedge clk);
        iv[k]   = 1'b0;
        ordy[k] = 1'b0;
        chk("hs_out_valid", ovld[k], 0);
        chk("hs_in_ready", irdy[k], 1);
    endtask

    task automatic set_pairs(input int k, input int a0, input int b0,
                             input bit rnd);
        qa.delete();
        qb.delete();
        for (int i = 0; i < blen(k); i++) begin
            qa.push_back(rnd ? int'($urandom_range(0, 15)) : a0);
            qb.push_back(rnd ? int'($urandom_range(0, 15)) : b0);
        end
    endtask

    initial begin
        int ea;
        int eo;
        int ea2;
        int eo2;
        int k;

        do_reset();

        // reset in the middle of a burst drops the partial sum
        for (int i = 0; i < 2; i++) begin
            iv[0] = 1'b1;
            ia[0] = 4'd15;
            ib[0] = 4'd15;
            @(negedge clk);
        end
        do_reset();
        set_pairs(0, 1, 1, 0);
        run_burst(0, 0, ea, eo);
        chk("after_reset_acc", racc(0), 4);
        release_out(0, 0, ea, eo);

        // back-to-back burst, then backpressure with in_valid held
        qa = '{3, 15, 0, 7};
        qb = '{5, 15, 9, 2};
        run_burst(0, 0, ea, eo);
        chk("b2b_acc", racc(0), 254);
        chk("b2b_ovf", oovf[0], 0);
        release_out(0, 5, ea, eo);

        // gapped input must match the gap-free result
        set_pairs(0, 0, 0, 1);
        run_burst(0, 1, ea, eo);
        release_out(0, 1, ea, eo);
        run_burst(0, 0, ea2, eo2);
        chk("gap_vs_nogap", racc(0), 32'(ea));
        release_out(0, 0, ea2, eo2);

        // overflow on the 8-bit instance
        set_pairs(1, 15, 15, 0);
        run_burst(1, 0, ea, eo);
`ifdef MUL4BIT_MAC_SATURATE_EN
        chk("ovf8_acc", racc(1), 255);
`else
        chk("ovf8_acc", racc(1), 132);
`endif
        chk("ovf8_flag", oovf[1], 1);
        release_out(1, 2, ea, eo);

        // single-pair bursts
        set_pairs(2, 9, 11, 0);
        run_burst(2, 0, ea, eo);
        chk("bl1_acc", racc(2), 99);
        release_out(2, 0, ea, eo);

        // random bursts across all three configurations
        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(0, 2));
            set_pairs(k, 0, 0, 1);
            run_burst(k, 1'($urandom), ea, eo);
            release_out(k, int'($urandom_range(0, 3)), ea, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
